ps_writeback: RTL and testbench

Writeback/commit stage that drives the two register-bank write channels (wrd_en1/wrd_add1/wrd_data1 and wrd_en2/wrd_add2/wrd_data2) consumed by the decode stage.
- Merges results from three execution sources:
  - single-cycle ALU path (cannot stall);
  - load unit;
  - mul/div unit.
- Load and mul/div results are buffered in a small pending FIFO.
- Enforces write ordering and same-address conflict rules, and supports pipeline flush.

---
 rtl/ps_writeback.sv | 181 ++++++++++++++++++
 tb/tb_ps_writeback.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps_writeback.sv
// Writeback/commit stage: merges the ALU, load and mul/div results onto two register-file write ports.
// Load and mul/div results wait in a small in-order pending FIFO; the ALU path never stalls.
module ps_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      alu_en,
    input  logic [4:0]                alu_add,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      ld_valid,
    input  logic [4:0]                ld_add,
    input  logic [XLEN-1:0]           ld_data,
    output logic                      ld_ready,
    input  logic                      md_valid,
    input  logic [4:0]                md_add,
    input  logic [XLEN-1:0]           md_data,
    output logic                      md_ready,
    output logic                      wrd_en1,
    output logic [4:0]                wrd_add1,
    output logic [XLEN-1:0]           wrd_data1,
    output logic                      wrd_en2,
    output logic [4:0]                wrd_add2,
    output logic [XLEN-1:0]           wrd_data2,
    output logic [$clog2(DEPTH):0]    pend_cnt,
    output logic                      busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      add_q  [DEPTH];
    logic [4:0]      add_d  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, head1_s, tail1_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            en1_q, en1_d, en2_q, en2_d;
    logic [4:0]      add1_q, add1_d, add2_q, add2_d;
    logic [XLEN-1:0] data1_q, data1_d, data2_q, data2_d;
    logic            ready_s, alu_hit_s, ld_push_s, md_push_s;
    logic            pop1_s, pop2_s, cand_v_s;
    logic [4:0]      cand_add_s;
    logic [XLEN-1:0] cand_data_s;
    logic [1:0]      n_push_s, n_pop_s;

    // Readiness depends only on the registered count so two pushes always fit.
    assign ready_s  = (cnt_q <= CW'(DEPTH - 2));
    assign ld_ready = ready_s;
    assign md_ready = ready_s;
    assign head1_s  = head_q + PW'(1);
    assign tail1_s  = tail_q + PW'(1);

    // Port selection on pre-push contents, FIFO push/pop and pointer/count update.
    always_comb begin
        add_d       = add_q;
        data_d      = data_q;
        en1_d       = 1'b0;
        add1_d      = add1_q;
        data1_d     = data1_q;
        en2_d       = 1'b0;
        add2_d      = add2_q;
        data2_d     = data2_q;
        pop1_s      = 1'b0;
        pop2_s      = 1'b0;
        cand_v_s    = 1'b0;
        cand_add_s  = 5'd0;
        cand_data_s = '0;
        alu_hit_s   = alu_en && (alu_add != 5'd0);
        ld_push_s   = !flush && ld_valid && ready_s && (ld_add != 5'd0);
        md_push_s   = !flush && md_valid && ready_s && (md_add != 5'd0);

        if (alu_hit_s) begin
            en1_d   = 1'b1;
            add1_d  = alu_add;
            data1_d = alu_data;
            if (!flush && (cnt_q != CW'(0))) begin
                cand_v_s    = 1'b1;
                cand_add_s  = add_q[head_q];
                cand_data_s = data_q[head_q];
            end else begin
                cand_v_s = 1'b0;
            end
        end else if (!flush && (cnt_q != CW'(0))) begin
            en1_d   = 1'b1;
            add1_d  = add_q[head_q];
            data1_d = data_q[head_q];
            pop1_s  = 1'b1;
            if (cnt_q >= CW'(2)) begin
                cand_v_s    = 1'b1;
                cand_add_s  = add_q[head1_s];
                cand_data_s = data_q[head1_s];
            end else begin
                cand_v_s = 1'b0;
            end
        end else begin
            en1_d = 1'b0;
        end

        // A same-address candidate stays queued so the newer port-1 value is not clobbered.
        if (cand_v_s && (cand_add_s != add1_d)) begin
            en2_d   = 1'b1;
            add2_d  = cand_add_s;
            data2_d = cand_data_s;
            pop2_s  = 1'b1;
        end else begin
            en2_d = 1'b0;
        end

        if (ld_push_s) begin
            add_d[tail_q]  = ld_add;
            data_d[tail_q] = ld_data;
        end else begin
            add_d[tail_q]  = add_d[tail_q];
        end
        if (md_push_s) begin
            add_d[ld_push_s ? tail1_s : tail_q]  = md_add;
            data_d[ld_push_s ? tail1_s : tail_q] = md_data;
        end else begin
            add_d[tail_q]  = add_d[tail_q];
        end

        n_push_s = {1'b0, ld_push_s} + {1'b0, md_push_s};
        n_pop_s  = {1'b0, pop1_s} + {1'b0, pop2_s};

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            head_d = head_q + PW'(n_pop_s);
            tail_d = tail_q + PW'(n_push_s);
            cnt_d  = cnt_q + CW'(n_push_s) - CW'(n_pop_s);
        end
        busy_d = (cnt_d != CW'(0));
    end

    // State and registered outputs, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                add_q[i]  <= 5'd0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            en1_q   <= 1'b0;
            add1_q  <= 5'd0;
            data1_q <= '0;
            en2_q   <= 1'b0;
            add2_q  <= 5'd0;
            data2_q <= '0;
        end else begin
            add_q   <= add_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            en1_q   <= en1_d;
            add1_q  <= add1_d;
            data1_q <= data1_d;
            en2_q   <= en2_d;
            add2_q  <= add2_d;
            data2_q <= data2_d;
        end
    end

    assign wrd_en1   = en1_q;
    assign wrd_add1  = add1_q;
    assign wrd_data1 = data1_q;
    assign wrd_en2   = en2_q;
    assign wrd_add2  = add2_q;
    assign wrd_data2 = data2_q;
    assign pend_cnt  = cnt_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_ps_writeback.sv
// Directed bench for ps_writeback with hand-computed expectations.
module tb_ps_writeback;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic        alu_en;
    logic [4:0]  alu_add;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_add;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        md_valid;
    logic [4:0]  md_add;
    logic [31:0] md_data;
    logic        md_ready;
    logic        wrd_en1, wrd_en2;
    logic [4:0]  wrd_add1, wrd_add2;
    logic [31:0] wrd_data1, wrd_data2;
    logic [2:0]  pend_cnt;
    logic        busy;
    int          n_chk = 0;
    int          n_err = 0;

    ps_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_en(alu_en), .alu_add(alu_add), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_add(ld_add), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_add(md_add), .md_data(md_data), .md_ready(md_ready),
        .wrd_en1(wrd_en1), .wrd_add1(wrd_add1), .wrd_data1(wrd_data1),
        .wrd_en2(wrd_en2), .wrd_add2(wrd_add2), .wrd_data2(wrd_data2),
        .pend_cnt(pend_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; alu_en = 1'b0; alu_add = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_add = 5'd0; ld_data = 32'd0;
        md_valid = 1'b0; md_add = 5'd0; md_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        alu_en = 1'b1; alu_add = a; alu_data = d;
    endtask

    task automatic ld(input logic [4:0] a, input logic [31:0] d);
        ld_valid = 1'b1; ld_add = a; ld_data = d;
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d);
        md_valid = 1'b1; md_add = a; md_data = d;
    endtask

    task automatic chk_p1(input string tag, input logic [4:0] a, input logic [31:0] d);
        check_val({tag, "_en1"}, 64'(wrd_en1), 64'd1);
        check_val({tag, "_add1"}, 64'(wrd_add1), 64'(a));
        check_val({tag, "_data1"}, 64'(wrd_data1), 64'(d));
    endtask

    task automatic chk_p2(input string tag, input logic [4:0] a, input logic [31:0] d);
        check_val({tag, "_en2"}, 64'(wrd_en2), 64'd1);
        check_val({tag, "_add2"}, 64'(wrd_add2), 64'(a));
        check_val({tag, "_data2"}, 64'(wrd_data2), 64'(d));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick(); tick();
        check_val("rst_en1", 64'(wrd_en1), 64'd0);
        check_val("rst_en2", 64'(wrd_en2), 64'd0);
        check_val("rst_add1", 64'(wrd_add1), 64'd0);
        check_val("rst_data1", 64'(wrd_data1), 64'd0);
        check_val("rst_cnt", 64'(pend_cnt), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ldrdy", 64'(ld_ready), 64'd1);
        check_val("rst_mdrdy", 64'(md_ready), 64'd1);
        reset = 1'b1;

        // 1: ALU single-cycle latency
        alu(5'd5, 32'hDEAD_BEEF);
        tick();
        chk_p1("t1", 5'd5, 32'hDEAD_BEEF);
        check_val("t1_en2", 64'(wrd_en2), 64'd0);
        idle();

        // 2: load + mul/div in one cycle, load first
        ld(5'd3, 32'h11); md(5'd4, 32'h22);
        tick();
        idle();
        check_val("t2_cnt_push", 64'(pend_cnt), 64'd2);
        check_val("t2_busy", 64'(busy), 64'd1);
        check_val("t2_en1_early", 64'(wrd_en1), 64'd0);
        tick();
        chk_p1("t2", 5'd3, 32'h11);
        chk_p2("t2", 5'd4, 32'h22);
        check_val("t2_cnt_drain", 64'(pend_cnt), 64'd0);
        check_val("t2_busy_drain", 64'(busy), 64'd0);

        // 3: ALU every cycle, port 2 drains loads in push order
        for (int i = 0; i < 4; i++) begin
            alu(5'(10 + i), 32'h100 + 32'(i));
            ld(5'(20 + i), 32'h200 + 32'(i));
            check_val("t3_ldrdy", 64'(ld_ready), 64'd1);
            tick();
            chk_p1("t3", 5'(10 + i), 32'h100 + 32'(i));
            if (i > 0) chk_p2("t3", 5'(19 + i), 32'h1FF + 32'(i));
            else check_val("t3_en2_first", 64'(wrd_en2), 64'd0);
            check_val("t3_cnt", 64'(pend_cnt), 64'd1);
        end
        idle();
        tick();
        chk_p1("t3_tail", 5'd23, 32'h203);
        check_val("t3_tail_en2", 64'(wrd_en2), 64'd0);
        check_val("t3_tail_cnt", 64'(pend_cnt), 64'd0);

        // 4: two queued entries to the same register serialise
        ld(5'd7, 32'hA); md(5'd7, 32'hB);
        tick();
        idle();
        tick();
        chk_p1("t4a", 5'd7, 32'hA);
        check_val("t4a_en2", 64'(wrd_en2), 64'd0);
        check_val("t4a_cnt", 64'(pend_cnt), 64'd1);
        tick();
        chk_p1("t4b", 5'd7, 32'hB);
        check_val("t4b_en2", 64'(wrd_en2), 64'd0);
        check_val("t4b_cnt", 64'(pend_cnt), 64'd0);

        // 5: fill to DEPTH-1 behind a same-address ALU stream, then flush
        alu(5'd9, 32'h90); ld(5'd9, 32'h1); md(5'd9, 32'h2);
        tick();
        check_val("t5_cnt2", 64'(pend_cnt), 64'd2);
        md_valid = 1'b0;
        alu(5'd9, 32'h91); ld(5'd9, 32'h3);
        tick();
        check_val("t5_cnt3", 64'(pend_cnt), 64'd3);
        check_val("t5_en2_blk", 64'(wrd_en2), 64'd0);
        check_val("t5_ldrdy0", 64'(ld_ready), 64'd0);
        check_val("t5_mdrdy0", 64'(md_ready), 64'd0);
        flush = 1'b1;
        alu(5'd9, 32'h99); ld(5'd9, 32'h4);
        tick();
        chk_p1("t5_flush", 5'd9, 32'h99);
        check_val("t5_flush_en2", 64'(wrd_en2), 64'd0);
        check_val("t5_flush_cnt", 64'(pend_cnt), 64'd0);
        check_val("t5_flush_rdy", 64'(ld_ready), 64'd1);
        check_val("t5_flush_busy", 64'(busy), 64'd0);
        idle();

        // 5b: flush without ALU drops a queued head and any same-cycle push
        ld(5'd6, 32'h66);
        tick();
        idle();
        flush = 1'b1;
        md(5'd8, 32'h88);
        tick();
        idle();
        check_val("t5b_en1", 64'(wrd_en1), 64'd0);
        check_val("t5b_en2", 64'(wrd_en2), 64'd0);
        check_val("t5b_cnt", 64'(pend_cnt), 64'd0);
        tick();
        check_val("t5b_after_en1", 64'(wrd_en1), 64'd0);

        // 6: x0 destinations are accepted and discarded
        ld(5'd0, 32'h55); alu(5'd0, 32'h77); md(5'd0, 32'h33);
        check_val("t6_ldrdy", 64'(ld_ready), 64'd1);
        tick();
        idle();
        check_val("t6_en1", 64'(wrd_en1), 64'd0);
        check_val("t6_en2", 64'(wrd_en2), 64'd0);
        check_val("t6_cnt", 64'(pend_cnt), 64'd0);
        tick();
        check_val("t6_en1_late", 64'(wrd_en1), 64'd0);

        // 6b: reset mid-queue overrides everything
        alu(5'd2, 32'h2222); ld(5'd8, 32'h88); md(5'd12, 32'hCC);
        tick();
        check_val("t6b_cnt", 64'(pend_cnt), 64'd2);
        reset = 1'b0;
        flush = 1'b1;
        tick();
        idle();
        check_val("t6b_en1", 64'(wrd_en1), 64'd0);
        check_val("t6b_add1", 64'(wrd_add1), 64'd0);
        check_val("t6b_data1", 64'(wrd_data1), 64'd0);
        check_val("t6b_en2", 64'(wrd_en2), 64'd0);
        check_val("t6b_cnt0", 64'(pend_cnt), 64'd0);
        check_val("t6b_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        tick();
        check_val("t6b_post_en1", 64'(wrd_en1), 64'd0);
        alu(5'd1, 32'h1234);
        tick();
        idle();
        chk_p1("t6b_post", 5'd1, 32'h1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
